fork_join_ctrl: RTL and testbench
=================================

// Module: fork_join_ctrl
// PURPOSE
//  Hardware fork/join supervisor. One start pulse launches N_CH parallel delay
//  channels ("children"). Each child completes after its own programmable delay.
//  The block reports completions, signals join per mode (JOIN / JOIN_ANY /
//  JOIN_NONE) and kills the surviving children on request ("disable fork").
//  It sits downstream of the per-task launch logic and feeds the sequencing
//  stage that runs after the join.
// PARAMETERS
//  N_CH   3  number of child channels (2..16)
//  DLY_W  8  width of each per-channel delay, in cycles
//  ID_W   $clog2(N_CH)  width of first_id (derived localparam, do not override)
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            asynchronous, active-low reset
//  start          in   1            launch request, one-cycle pulse
//  mode           in   2            0=JOIN, 1=JOIN_ANY, 2=JOIN_NONE, 3=treated as JOIN; sampled with start
//  delay_i        in   N_CH*DLY_W   delay of channel i in bits [i*DLY_W +: DLY_W]; sampled with start
//  kill           in   1            disable fork: stop every still-running child
//  busy           out  1            high while any child is running
//  ch_done_pulse  out  N_CH         one-cycle pulse when channel i completes
//  join_done      out  1            one-cycle pulse when the join condition is met
//  all_done       out  1            one-cycle pulse when every child has completed or been killed
//  first_vld      out  1            first_id is valid; held until the next accepted start
//  first_id       out  ID_W         index of the first completing child
//  done_mask      out  N_CH         sticky: children that completed
//  killed_mask    out  N_CH         sticky: children that were killed
// BEHAVIOUR
//  - Reset (async assert): all outputs 0, all counters 0, FSM=IDLE. Reset mid-run aborts all children with no pulses.
//  - FSM states:
//     IDLE: start accepted here; leaves for WAIT_JOIN, or DETACHED when mode=JOIN_NONE.
//     WAIT_JOIN: join not yet satisfied; leaves for DETACHED when join is met.
//     DETACHED: join satisfied, children may still run.
//    From WAIT_JOIN or DETACHED, go to IDLE on the edge where the running set becomes empty.
//  - Accepted start on edge E0: loads counters, sets every running bit, clears done/killed masks and first_vld.
//    Start is ignored while busy.
//  - Timing: channel i with delay d pulses ch_done_pulse[i] at edge E0+d+1. Delay 0 pulses at E0+1.
//    Counters decrement by 1 per cycle and never wrap.
//  - join_done is registered and asserts on the same edge as the satisfying event:
//     JOIN: last child's completion.
//     JOIN_ANY: first completion.
//     JOIN_NONE: edge E0+1, unconditionally.
//  - first_id/first_vld are set on the first completion in any mode.
//    For simultaneous completions, the lowest index wins.
//  - all_done pulses on the edge busy falls, whether by completion or by kill.
//  - Children left running after a join keep running until they complete or are killed (SV fork semantics).
//  - kill high on an edge: every running child stops and its killed_mask bit is set. No ch_done_pulse for it.
//    If the join is unmet, join_done never fires for that run.
//  - kill and completion on the same edge: completion wins for that channel.
//  - kill while IDLE has no effect.
//  - start+kill in the same IDLE cycle: start is accepted and kill is ignored.
//  - Invariants: done_mask & killed_mask == 0; busy == |running.
// TESTING
//  1. ANY, delays{ch0,ch1,ch2}={30,7,10}:
//     ch1 pulse and join_done at E0+8, first_id=1, ch2 at E0+11, ch0 and all_done at E0+31.
//  2. Same run with kill at E0+12:
//     killed_mask=001, done_mask=110, no ch0 pulse, all_done at E0+12, busy=0 after.
//  3. JOIN, delays{5,5,2}:
//     ch2 at E0+3, ch0 and ch1 at E0+6, join_done and all_done at E0+6, first_id=2.
//  4. ANY, delays{4,4,9}:
//     ch0 and ch1 pulse together at E0+5, first_id=0, a single join_done.
//  5. JOIN, delays{20,20,20}, kill at E0+3:
//     no join_done, killed_mask=111, first_vld=0, all_done at E0+3.
//  6. NONE, delays{0,3,3}: join_done and ch0 at E0+1.
//     Then start at E0+2 is ignored; then rst_n low at E0+3 clears all outputs at once, with no further pulses.

Source files
------------

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl
//   Hardware fork/join supervisor. One accepted start launches N_CH delay
//   channels ("children"). Each child finishes d+1 cycles after launch. The
//   block reports each completion and signals the join according to the
//   mode latched at start (JOIN, JOIN_ANY or JOIN_NONE). A kill request stops
//   every child that is still running ("disable fork").
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          launch request (one-cycle pulse), ignored while busy
//   mode           0=JOIN, 1=JOIN_ANY, 2=JOIN_NONE, 3=JOIN; sampled with start
//   delay_i        per-channel delay, channel i in [i*DLY_W +: DLY_W]
//   kill           stop every still-running child
//   busy           any child running
//   ch_done_pulse  one-cycle pulse per completing channel
//   join_done      one-cycle pulse when the join condition is met
//   all_done       one-cycle pulse on the edge busy falls
//   first_vld      first_id valid, held until the next accepted start
//   first_id       index of the first completing child (lowest index on ties)
//   done_mask      sticky set of completed children
//   killed_mask    sticky set of killed children
module fork_join_ctrl #(
  parameter int N_CH  = 3,
  parameter int DLY_W = 8,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [N_CH*DLY_W-1:0]   delay_i,
  input  logic                    kill,
  output logic                    busy,
  output logic [N_CH-1:0]         ch_done_pulse,
  output logic                    join_done,
  output logic                    all_done,
  output logic                    first_vld,
  output logic [ID_W-1:0]         first_id,
  output logic [N_CH-1:0]         done_mask,
  output logic [N_CH-1:0]         killed_mask
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_JOIN = 2'd1;
  localparam logic [1:0] S_DETACHED  = 2'd2;

  localparam logic [1:0] M_ANY  = 2'd1;
  localparam logic [1:0] M_NONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [1:0]       mode_reg;
  logic [N_CH-1:0]  running_reg, running_next;
  logic [N_CH-1:0]  comp;       // channel completes on this edge
  logic [N_CH-1:0]  kill_hit;   // channel is killed on this edge
  logic [DLY_W-1:0] cnt_reg [N_CH];
  logic             none_pend_reg;
  logic             accept, join_met, run_ends;
  logic [ID_W-1:0]  low_id;

  assign busy   = |running_reg;
  assign accept = (state_reg == S_IDLE) && start && !busy;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // A running counter that has reached zero completes on this edge; a
    // completion takes precedence over a simultaneous kill.
    assign comp[gi]     = running_reg[gi] && (cnt_reg[gi] == '0);
    assign kill_hit[gi] = kill && running_reg[gi] && !comp[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg[gi] <= '0;
      end else if (accept) begin
        cnt_reg[gi] <= delay_i[gi*DLY_W +: DLY_W];
      end else if (running_reg[gi] && (cnt_reg[gi] != '0)) begin
        cnt_reg[gi] <= cnt_reg[gi] - DLY_W'(1);
      end
    end
  end

  assign running_next = running_reg & ~comp & ~kill_hit;
  assign run_ends     = busy && (running_next == '0);

  // Lowest completing index wins on simultaneous completions.
  always_comb begin
    low_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (comp[i]) low_id = ID_W'(i);
    end
  end

  // JOIN needs every child to have completed; any kill makes it unreachable
  // because a killed child never appears in comp.
  always_comb begin
    case (mode_reg)
      M_ANY:   join_met = |comp;
      M_NONE:  join_met = 1'b0;
      default: join_met = (|comp) && ((running_reg & ~comp) == '0);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = (mode == M_NONE) ? S_DETACHED : S_WAIT_JOIN;
      end
      S_WAIT_JOIN: begin
        if (run_ends)      state_next = S_IDLE;
        else if (join_met) state_next = S_DETACHED;
      end
      S_DETACHED: begin
        if (run_ends) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      mode_reg      <= '0;
      running_reg   <= '0;
      none_pend_reg <= 1'b0;
      ch_done_pulse <= '0;
      join_done     <= 1'b0;
      all_done      <= 1'b0;
      first_vld     <= 1'b0;
      first_id      <= '0;
      done_mask     <= '0;
      killed_mask   <= '0;
    end else begin
      state_reg     <= state_next;
      ch_done_pulse <= comp;
      all_done      <= run_ends;
      // JOIN_NONE joins one cycle after launch regardless of the children.
      none_pend_reg <= accept && (mode == M_NONE);
      join_done     <= ((state_reg == S_WAIT_JOIN) && join_met) || none_pend_reg;
      if (accept) begin
        running_reg <= '1;
        mode_reg    <= mode;
        done_mask   <= '0;
        killed_mask <= '0;
        first_vld   <= 1'b0;
        first_id    <= '0;
      end else begin
        running_reg <= running_next;
        done_mask   <= done_mask | comp;
        killed_mask <= killed_mask | kill_hit;
        if (!first_vld && (|comp)) begin
          first_vld <= 1'b1;
          first_id  <= low_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed testbench for fork_join_ctrl (N_CH=3, DLY_W=8). Each run computes
// the expected per-cycle trace from the channel timing rules, queues it, and
// pops one entry per clock as the DUT produces output.
module tb_fork_join_ctrl;
  localparam int N_CH  = 3;
  localparam int DLY_W = 8;
  localparam int ID_W  = $clog2(N_CH);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [1:0]            mode;
  logic [N_CH*DLY_W-1:0] delay_i;
  logic                  kill;
  logic                  busy;
  logic [N_CH-1:0]       ch_done_pulse;
  logic                  join_done;
  logic                  all_done;
  logic                  first_vld;
  logic [ID_W-1:0]       first_id;
  logic [N_CH-1:0]       done_mask;
  logic [N_CH-1:0]       killed_mask;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];   // {busy, ch_done_pulse, join_done, all_done}

  always #5 clk = ~clk;

  fork_join_ctrl #(.N_CH(N_CH), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .delay_i(delay_i),
    .kill(kill), .busy(busy), .ch_done_pulse(ch_done_pulse),
    .join_done(join_done), .all_done(all_done), .first_vld(first_vld),
    .first_id(first_id), .done_mask(done_mask), .killed_mask(killed_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // kill_at: edge offset after launch where kill is high (0 = never).
  task automatic run_case(input string name, input logic [1:0] m,
                          input int d0, input int d1, input int d2,
                          input int kill_at, input logic kill_with_start);
    int t[3];
    int maxt, endk, last, first;
    logic [2:0] kmask, dmask, pls;
    logic fv, jd;
    logic [1:0] fid;
    logic [5:0] e, o;
    t[0] = d0 + 1; t[1] = d1 + 1; t[2] = d2 + 1;
    maxt = t[0];
    for (int i = 1; i < 3; i++) if (t[i] > maxt) maxt = t[i];
    kmask = '0;
    for (int i = 0; i < 3; i++) if (kill_at != 0 && kill_at < t[i]) kmask[i] = 1'b1;
    dmask = ~kmask;
    endk  = (kmask != 0) ? kill_at : maxt;
    fv    = (dmask != 0);
    first = 1000; fid = '0;
    for (int i = 0; i < 3; i++) if (dmask[i] && t[i] < first) begin first = t[i]; fid = 2'(i); end
    last = endk + 2;
    for (int k = 1; k <= last; k++) begin
      for (int i = 0; i < 3; i++) pls[i] = dmask[i] && (t[i] == k);
      if (m == 2'd2)      jd = (k == 1);
      else if (m == 2'd1) jd = fv && (k == first);
      else                jd = (kmask == 0) && (k == maxt);
      exp_q.push_back({(k < endk), pls, jd, (k == endk)});
    end

    @(negedge clk);
    mode = m;
    delay_i = {8'(d2), 8'(d1), 8'(d0)};
    start = 1'b1;
    kill = kill_with_start;
    @(posedge clk);            // E0
    #1 start = 1'b0; kill = 1'b0;
    check({name, " busy@E0"}, busy, 1);
    check({name, " masks@E0"}, {first_vld, done_mask, killed_mask}, 0);
    for (int k = 1; k <= last; k++) begin
      kill = (k == kill_at);
      @(posedge clk);
      #1 kill = 1'b0;
      o = {busy, ch_done_pulse, join_done, all_done};
      e = exp_q.pop_front();
      check($sformatf("%s k=%0d", name, k), o, e);
      $display("txn %s k=%0d out=%b exp=%b", name, k, o, e);
    end
    check({name, " done_mask"}, done_mask, dmask);
    check({name, " killed_mask"}, killed_mask, kmask);
    check({name, " first_vld"}, first_vld, fv);
    if (fv) check({name, " first_id"}, first_id, fid);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; mode = '0; delay_i = '0;
    #2;
    check("reset outputs", {busy, ch_done_pulse, join_done, all_done, first_vld,
                            first_id, done_mask, killed_mask}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_case("t1_any",      2'd1, 30, 7, 10, 0,  1'b0);
    run_case("t2_any_kill", 2'd1, 30, 7, 10, 12, 1'b0);
    run_case("t3_join",     2'd0, 5, 5, 2,   0,  1'b0);
    run_case("t4_any_tie",  2'd1, 4, 4, 9,   0,  1'b0);
    run_case("t5_join_kill",2'd0, 20, 20, 20, 3, 1'b0);
    run_case("t6_none",     2'd2, 0, 3, 3,   0,  1'b0);
    run_case("mode3_join",  2'd3, 2, 4, 1,   0,  1'b0);
    run_case("kill_vs_comp",2'd0, 4, 9, 9,   5,  1'b0);
    run_case("start_kill",  2'd1, 2, 3, 1,   0,  1'b1);
    run_case("zero_delay",  2'd0, 0, 0, 0,   0,  1'b0);
    run_case("none_kill",   2'd2, 5, 5, 5,   1,  1'b0);

    // kill while idle leaves the previous run's record untouched
    @(negedge clk) kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("idle kill masks", {busy, done_mask, killed_mask}, {1'b0, 3'b000, 3'b111});

    // NONE {0,3,3}: ignored restart, then async reset mid-run
    @(negedge clk);
    mode = 2'd2; delay_i = {8'd3, 8'd3, 8'd0}; start = 1'b1;
    @(posedge clk);            // E0
    #1 start = 1'b0;
    @(posedge clk);            // E0+1
    #1;
    check("t6b E0+1 pulse/join", {ch_done_pulse, join_done}, {3'b001, 1'b1});
    mode = 2'd0; delay_i = {8'd1, 8'd1, 8'd1}; start = 1'b1;
    @(posedge clk);            // E0+2, start must be ignored
    #1 start = 1'b0;
    check("t6b ignored start", {busy, done_mask, first_vld, join_done}, {1'b1, 3'b001, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("t6b async reset", {busy, ch_done_pulse, join_done, all_done, first_vld,
                              first_id, done_mask, killed_mask}, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t6b quiet k=%0d", k), {busy, ch_done_pulse, join_done, all_done}, 0);
    end
    @(negedge clk) rst_n = 1'b1;

    run_case("after_reset", 2'd1, 1, 0, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
